// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the requesters, the round-robin arbiter and the FIFO write side.
// The arbiter takes the master modport and the surrounding logic takes the slave modport.
interface fifo_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned STALL_CNT_W = 16
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          full;
  logic                          write_en;
  logic [DATA_WIDTH-1:0]         write_data;
  logic                          busy;
  logic [STALL_CNT_W-1:0]        stall_cnt;

  modport master (
    input  req, req_data, full,
    output ack, grant, write_en, write_data, busy, stall_cnt
  );

  modport slave (
    output req, req_data, full,
    input  ack, grant, write_en, write_data, busy, stall_cnt
  );

endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grants are limited to bounded bursts, and every grant costs one idle arbitration cycle.
module fifo_write_arbiter #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned REQ_IDX_W   = 2,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  fifo_write_arbiter_if.master  bus
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [REQ_IDX_W-1:0]   owner_q, owner_d;
  logic [REQ_IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;

  logic                   found;
  logic [REQ_IDX_W-1:0]   pick;
  int unsigned            idx;
  logic                   owner_req;
  logic                   write_en;
  logic                   last_beat;

  // Rotating priority search that starts just after the previous owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_owner_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = REQ_IDX_W'(idx);
      end
    end
  end

  assign owner_req = bus.req[owner_q];
  // Gated by reset as well, so the FIFO never sees a write on the edge that takes reset.
  assign write_en  = reset && (state_q == StGrant) && owner_req && !bus.full;
  assign last_beat = (beat_cnt_q == 4'(BURST_LEN - 1));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    grant_d      = grant_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          owner_d    = pick;
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (write_en) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end else if (owner_req && bus.full && (stall_cnt_q != '1)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
        // Release happens when the requester withdraws or when the last beat of the burst is taken.
        if (!owner_req || (write_en && last_beat)) begin
          last_owner_d = owner_q;
          grant_d      = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= REQ_IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      grant_q      <= grant_d;
    end
  end

  assign bus.write_en   = write_en;
  assign bus.write_data = bus.req_data[32'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.ack        = write_en ? grant_q : '0;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q == StGrant);
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter. It uses directed and random requester and full
// traffic, and a cycle-level reference model that tracks the current owner, the round-robin
// pointer and the number of beats in the current burst.
module tb_fifo_write_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned BL = 4;
  localparam int unsigned SW = 4;
  localparam int NCYC = 680;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .STALL_CNT_W(SW)) bus ();

  fifo_write_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .REQ_IDX_W  (IW),
    .BURST_LEN  (BL),
    .STALL_CNT_W(SW)
  ) dut (
    .wr_clk(clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0] grant;
    logic          busy;
    logic [SW-1:0] stall;
  } status_t;

  typedef struct {
    logic [NR-1:0] ack;
    logic [DW-1:0] data;
  } wr_t;

  status_t sq[$];
  wr_t     wq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: owner of -1 means nobody holds the port.
  int m_owner = -1;
  int m_last  = NR - 1;
  int m_beats = 0;
  int m_stall = 0;
  logic [NR-1:0] cur_req = '0;
  logic [DW-1:0] cur_data[NR];
  logic          cur_full = 1'b0;
  logic          cur_rst = 1'b0;
  logic [NR-1:0] last_ack = '0;

  function automatic void model_step();
    if (!cur_rst) begin
      m_owner = -1;
      m_last  = NR - 1;
      m_beats = 0;
      m_stall = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int cand;
        cand = (m_last + k) % NR;
        if (cur_req[cand]) begin
          m_owner = cand;
          m_beats = 0;
          break;
        end
      end
    end else if (!cur_req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (cur_full) begin
      if (m_stall < (1 << SW) - 1) m_stall++;
    end else begin
      m_beats++;
      if (m_beats == BL) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endfunction

  logic [DW-1:0] fixed_val[NR];

  initial begin
    status_t s;
    wr_t     w;
    int      mode;
    logic    exp_we;
    fixed_val[0] = 8'hA1; fixed_val[1] = 8'hB2; fixed_val[2] = 8'hC3; fixed_val[3] = 8'hD4;
    for (int i = 0; i < NR; i++) cur_data[i] = '0;
    bus.req = '0;
    bus.req_data = '0;
    bus.full = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      model_step();
      // mode 0: requester 0 only; 1: all requesters continuous; 2: random traffic
      mode = (c < 25) ? 0 : (c < 80) ? 1 : (c < 600) ? 2 : 1;
      cur_rst = !(c < 3 || c == 40 || (mode == 2 && $urandom_range(0, 99) == 0));
      if (mode == 2) cur_full = ($urandom_range(0, 99) < 30);
      else cur_full = (c >= 600 && c < 640);
      for (int i = 0; i < NR; i++) begin
        if (mode == 0) begin
          cur_req[i]  = (i == 0) && (c >= 3);
          cur_data[i] = fixed_val[i];
        end else if (mode == 1) begin
          cur_req[i]  = 1'b1;
          cur_data[i] = fixed_val[i];
        end else if (cur_req[i] && !last_ack[i]) begin
          if ($urandom_range(0, 99) < 3) cur_req[i] = 1'b0;
        end else begin
          cur_req[i]  = ($urandom_range(0, 99) < 60);
          cur_data[i] = DW'($urandom);
        end
      end
      rst_n    = cur_rst;
      bus.full = cur_full;
      bus.req  = cur_req;
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = cur_data[i];
      exp_we   = cur_rst && (m_owner >= 0) && cur_req[m_owner] && !cur_full;
      last_ack = exp_we ? NR'(1 << m_owner) : '0;
      s.grant  = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
      s.busy   = (m_owner >= 0);
      s.stall  = SW'(m_stall);
      sq.push_back(s);
      if (exp_we) begin
        w.ack  = last_ack;
        w.data = cur_data[m_owner];
        wq.push_back(w);
      end
    end
    @(negedge clk);
    #1;
    chk("status_queue_drained", 32'(sq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    status_t s;
    wr_t     w;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("grant", 32'(bus.grant), 32'(s.grant));
        chk("busy", 32'(bus.busy), 32'(s.busy));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(s.stall));
        chk("write_while_full", 32'(bus.write_en & bus.full), 0);
        if (bus.write_en) begin
          if (wq.size() == 0) begin
            chk("unexpected_write", 32'(bus.write_en), 0);
          end else begin
            w = wq.pop_front();
            chk("ack", 32'(bus.ack), 32'(w.ack));
            chk("write_data", 32'(bus.write_data), 32'(w.data));
          end
        end else begin
          chk("ack_idle", 32'(bus.ack), 0);
        end
        chk("missing_write", 32'(wq.size()), 0);
        wq.delete();
      end
    end
  end

endmodule
